shake_squeeze_piso: RTL and testbench
=====================================

# shake_squeeze_piso

Output-side serializer for the SHAKE core: accepts one rate block from the Keccak permutation in parallel and emits it as 64-bit words over a valid/ready stream until a requested output length is reached. When a block is exhausted before the length is met, it requests the next permutation. It is the counterpart of the input-side word loader and sits between the Keccak state register and the downstream consumer (sampler/expander).

## Interface
- WORD_W, 64, output word width (Keccak lane)
- MAX_RATE_W, 1344, width of the block input (SHAKE128 rate)
- LEN_W, 16, width of the output length in words

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin squeeze; sampled only in IDLE
- mode  in  1  0 = SHAKE128 (21 words/block), 1 = SHAKE256 (17 words/block); latched on start
- out_len  in  LEN_W  number of words to emit; latched on start
- blk_req  out  1  level request for a new permuted block
- blk_valid  in  1  blk_data valid; accepted only while blk_req = 1
- blk_data  in  MAX_RATE_W  rate bits, lane 0 in bits [63:0]; bits above 1087 ignored when mode = 1
- dout  out  WORD_W  output word
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts dout
- done  out  1  one-cycle pulse after the final word transfers
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, WAIT_BLK, EMIT, FIN.
- IDLE: on start, latch mode and out_len into remaining. If out_len = 0, go to FIN. Otherwise go to WAIT_BLK.
- WAIT_BLK: blk_req = 1. On blk_valid:
  - load blk_data into the shift register;
  - set word_idx = 0;
  - go to EMIT.
- EMIT:
  - dout = shreg[63:0]; dout_valid = 1.
  - A transfer occurs when dout_valid & dout_ready. On a transfer:
    - shift shreg right by WORD_W;
    - word_idx += 1;
    - remaining -= 1.
  - After a transfer, if remaining becomes 0, go to FIN.
  - Otherwise, if word_idx reaches the rate word count (21 or 17), go to WAIT_BLK.
  - Otherwise stay in EMIT.
- FIN: done = 1 for exactly one cycle, then go to IDLE.
- start is ignored outside IDLE. blk_valid is ignored outside WAIT_BLK.
- Words within a block go out in lane order 0, 1, 2, …; no reordering across blocks.
- Counters: word_idx is 5 bits; remaining is LEN_W bits and never underflows (FIN entered at 0).

## Timing
- Reset values: blk_req 0, dout 0, dout_valid 0, done 0, busy 0; state IDLE; shreg, word_idx and remaining all 0.
- start → blk_req high on the next cycle.
- blk_valid accepted at edge N → dout_valid high from cycle N+1; blk_req low from N+1.
- Throughput is one word per cycle while dout_ready is held high.
- Block boundary costs 1 + (upstream latency) cycles, with dout_valid low throughout.
- Last-word transfer at edge N → done high during cycle N+1; busy low from N+2.
- Stall rule: while dout_valid & !dout_ready, dout is stable and no counter changes.
- dout_valid drops only after a transfer or on rst.
- blk_req stays high until blk_valid; it is never withdrawn.
- rst mid-squeeze: all state is cleared on the next edge, the partial block is discarded, and no done pulse is produced.

## Structure
- Package shake_pkg holds:
  - WORD_W;
  - RATE128_WORDS = 21, RATE256_WORDS = 17;
  - RATE128_BITS = 1344, RATE256_BITS = 1088;
  - the state enum typedef squeeze_state_t.
- One sub-module: shake_piso_shreg. It is a MAX_RATE_W parallel-load, WORD_W-step right-shift register with load/shift enables and sync reset; it exposes the low word.
- FSM and counters live in the top module.

## Test plan
- SHAKE128, out_len = 3, dout_ready tied 1, block lanes = 0x…01, 0x…02, 0x…03 → three words 1, 2, 3 on consecutive cycles. done one cycle after the third transfer. blk_req asserted exactly once.
- SHAKE256, out_len = 20 → 17 words from block A, then blk_req re-asserts; 3 words from block B lanes 0–2. Total 20 transfers, exactly 2 block requests.
- out_len = 0 → done pulses on the cycle after FIN is entered, no blk_req, and dout_valid never rises.
- dout_ready toggled randomly, 50%, SHAKE128 out_len = 42 → dout stable during every stall. Sequence equals lanes 0–20 of block A then lanes 0–20 of block B; no drops or duplicates.
- rst asserted after the 5th word of a 10-word squeeze → all outputs 0 the next cycle, no done. A new start with out_len = 2 then completes normally.
- start pulsed in EMIT and blk_valid pulsed in EMIT → both ignored; output sequence unchanged.

Source files
------------

// File: rtl/shake_pkg.sv
// Shared constants and types for the SHAKE squeeze path.
//   WORD_W          : width of one Keccak lane / output word
//   RATE*_WORDS     : lanes per rate block for SHAKE128 / SHAKE256
//   RATE*_BITS      : rate block width in bits for SHAKE128 / SHAKE256
//   squeeze_state_t : state encoding of the output serializer FSM
package shake_pkg;

  localparam int WORD_W        = 64;
  localparam int RATE128_WORDS = 21;
  localparam int RATE256_WORDS = 17;
  localparam int RATE128_BITS  = 1344;
  localparam int RATE256_BITS  = 1088;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BLK,
    EMIT,
    FIN
  } squeeze_state_t;

endpackage

// File: rtl/shake_piso_shreg.sv
// Parallel-in / word-serial-out shift register for one rate block.
//   clk, rst : clock and synchronous active-high reset
//   load     : capture din (takes priority over shift)
//   shift    : move contents right by one word, zero-filling the top
//   din      : full rate block, lane 0 in the low word
//   low_word : current lowest word, i.e. the next lane to be emitted
module shake_piso_shreg #(
  parameter int WIDTH = 1344,
  parameter int STEP  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic [STEP-1:0]  low_word
);

  logic [WIDTH-1:0] shreg;

  // A load always wins so a fresh block is never mixed with a pending shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {{STEP{1'b0}}, shreg[WIDTH-1:STEP]};
    end
  end

  assign low_word = shreg[STEP-1:0];

endmodule

// File: rtl/shake_squeeze_piso.sv
// Output-side serializer of the SHAKE core. Takes permuted rate blocks in
// parallel and streams them out as 64-bit lanes until out_len words have
// been delivered, requesting a new permutation whenever a block runs dry.
//   clk, rst   : clock and synchronous active-high reset
//   start      : begin a squeeze (only looked at while idle)
//   mode       : 0 = SHAKE128 (21 lanes/block), 1 = SHAKE256 (17 lanes/block)
//   out_len    : number of words to emit
//   blk_req    : level request for the next permuted block
//   blk_valid  : blk_data valid, taken only while blk_req is high
//   blk_data   : rate bits, lane 0 in bits [63:0]
//   dout       : output word
//   dout_valid : dout holds a valid word
//   dout_ready : consumer accepts dout
//   done       : one-cycle pulse after the final word transfers
//   busy       : squeeze in progress
module shake_squeeze_piso
  import shake_pkg::*;
#(
  parameter int MAX_RATE_W = RATE128_BITS,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [LEN_W-1:0]      out_len,
  output logic                  blk_req,
  input  logic                  blk_valid,
  input  logic [MAX_RATE_W-1:0] blk_data,
  output logic [WORD_W-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  done,
  output logic                  busy
);

  // Only the low RATE256_BITS of the block carry rate data in SHAKE256.
  localparam logic [MAX_RATE_W-1:0] MASK256 =
    {{(MAX_RATE_W-RATE256_BITS){1'b0}}, {RATE256_BITS{1'b1}}};

  squeeze_state_t         state;
  logic                   mode_q;
  logic [LEN_W-1:0]       remaining;
  logic [4:0]             word_idx;
  logic [4:0]             rate_words;
  logic [MAX_RATE_W-1:0]  blk_masked;
  logic                   load_blk;
  logic                   xfer;

  assign rate_words = mode_q ? 5'(RATE256_WORDS) : 5'(RATE128_WORDS);
  assign blk_masked = mode_q ? (blk_data & MASK256) : blk_data;
  assign load_blk   = (state == WAIT_BLK) && blk_valid;
  // dout_valid is high for the whole of EMIT, so ready alone marks a transfer.
  assign xfer       = (state == EMIT) && dout_ready;

  shake_piso_shreg #(
    .WIDTH (MAX_RATE_W),
    .STEP  (WORD_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load_blk),
    .shift    (xfer),
    .din      (blk_masked),
    .low_word (dout)
  );

  // Control FSM. All status outputs are registered and updated together
  // with the state so they line up exactly with the state they describe.
  // The end-of-length test wins over the end-of-block test so a squeeze
  // that ends on a block boundary never asks for an unneeded permutation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      remaining  <= '0;
      word_idx   <= '0;
      blk_req    <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            remaining <= out_len;
            busy      <= 1'b1;
            if (out_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state   <= WAIT_BLK;
              blk_req <= 1'b1;
            end
          end
        end
        WAIT_BLK: begin
          if (blk_valid) begin
            word_idx   <= '0;
            state      <= EMIT;
            blk_req    <= 1'b0;
            dout_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (dout_ready) begin
            word_idx  <= word_idx + 5'd1;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state      <= FIN;
              dout_valid <= 1'b0;
              done       <= 1'b1;
            end else if ((word_idx + 5'd1) == rate_words) begin
              state      <= WAIT_BLK;
              dout_valid <= 1'b0;
              blk_req    <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shake_squeeze_piso.sv
// Self-checking bench for shake_squeeze_piso. A table of squeeze jobs is run
// against a reference that simply indexes the supplied blocks lane by lane;
// the bench also plays the role of the permutation (random latency) and of
// a randomly stalling consumer. Hand-written sequences cover reset.
module tb_shake_squeeze_piso;
  import shake_pkg::*;

  localparam int LEN_W      = 16;
  localparam int MAX_RATE_W = 1344;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  mode;
  logic [LEN_W-1:0]      out_len;
  logic                  blk_req;
  logic                  blk_valid;
  logic [MAX_RATE_W-1:0] blk_data;
  logic [WORD_W-1:0]     dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  done;
  logic                  busy;

  always #5 clk = ~clk;

  shake_squeeze_piso #(
    .MAX_RATE_W (MAX_RATE_W),
    .LEN_W      (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .out_len    (out_len),
    .blk_req    (blk_req),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .done       (done),
    .busy       (busy)
  );

  typedef struct {
    logic m;
    int   len;
    int   readyPct;
    int   maxLat;
    int   expReqs;
    int   expDoneCyc;
    bit   fixedLanes;
  } vec_t;

  vec_t                  vecs[9];
  logic [MAX_RATE_W-1:0] blocks[4];
  int                    checks = 0;
  int                    errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [MAX_RATE_W-1:0] randomBlock();
    logic [MAX_RATE_W-1:0] b;
    for (int i = 0; i < MAX_RATE_W / 32; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic fillBlocks(input bit fixedLanes);
    for (int b = 0; b < 4; b++) begin
      blocks[b] = randomBlock();
      if (fixedLanes)
        for (int l = 0; l < 21; l++) blocks[b][64*l +: 64] = 64'(b * 21 + l + 1);
    end
  endtask

  // Word n of the squeeze is lane (n mod rate) of the (n div rate)-th block.
  function automatic logic [63:0] expWord(input int n, input logic m);
    int rate;
    rate = m ? RATE256_WORDS : RATE128_WORDS;
    return blocks[n / rate][64 * (n % rate) +: 64];
  endfunction

  task automatic applyStimulus(input vec_t v);
    int   cyc, xfers, reqs, dones, lat, doneCyc, lastXferCyc;
    logic prevStall, prevReq, prevAccept, ready, accept;
    logic [63:0] prevDout;
    fillBlocks(v.fixedLanes);
    @(negedge clk);
    start      = 1'b1;
    mode       = v.m;
    out_len    = LEN_W'(v.len);
    dout_ready = 1'b0;
    blk_valid  = 1'b0;
    cyc = 0; xfers = 0; reqs = 0; dones = 0; doneCyc = -1; lastXferCyc = 0;
    prevStall = 1'b0; prevReq = 1'b0; prevAccept = 1'b0; prevDout = '0;
    lat = $urandom_range(v.maxLat, 0);
    while (dones == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start   = 1'b0;
      mode    = 1'($urandom);
      out_len = LEN_W'($urandom);
      if (cyc == 1) begin
        checkOutput("busy after start", 64'(busy), 64'd1);
        if (v.len == 0) begin
          checkOutput("done after zero-length start", 64'(done), 64'd1);
          checkOutput("zero-length blk_req", 64'(blk_req), 64'd0);
          checkOutput("zero-length dout_valid", 64'(dout_valid), 64'd0);
        end else begin
          checkOutput("blk_req after start", 64'(blk_req), 64'd1);
        end
      end
      if (prevStall) begin
        checkOutput("stall dout stable", dout, prevDout);
        checkOutput("stall dout_valid held", 64'(dout_valid), 64'd1);
      end
      if (prevReq && !prevAccept) checkOutput("blk_req held", 64'(blk_req), 64'd1);
      if (done) begin
        dones++;
        doneCyc = cyc;
      end
      ready      = ($urandom_range(99, 0) < v.readyPct);
      dout_ready = ready;
      if (busy && !done && $urandom_range(7, 0) == 0) start = 1'b1;
      accept = 1'b0;
      if (blk_req) begin
        if (lat == 0) begin
          blk_valid = 1'b1;
          blk_data  = blocks[reqs < 4 ? reqs : 3];
          accept    = 1'b1;
          reqs++;
          lat = $urandom_range(v.maxLat, 0);
        end else begin
          lat--;
          blk_valid = 1'b0;
          blk_data  = randomBlock();
        end
      end else begin
        blk_valid = 1'($urandom_range(1, 0));
        blk_data  = randomBlock();
      end
      if (dout_valid && ready) begin
        if (xfers < v.len)
          checkOutput($sformatf("word %0d of len %0d", xfers, v.len), dout, expWord(xfers, v.m));
        else
          checkOutput("word beyond length", 64'(dout_valid), 64'd0);
        xfers++;
        lastXferCyc = cyc;
      end
      prevStall  = dout_valid && !ready;
      prevDout   = dout;
      prevReq    = blk_req;
      prevAccept = accept;
    end
    checkOutput("transfer count", 64'(xfers), 64'(v.len));
    checkOutput("block requests", 64'(reqs), 64'(v.expReqs));
    checkOutput("done seen", 64'(dones), 64'd1);
    checkOutput("done timing", 64'(doneCyc), 64'(v.len == 0 ? 1 : lastXferCyc + 1));
    if (v.expDoneCyc != 0) checkOutput("full-rate cycle count", 64'(doneCyc), 64'(v.expDoneCyc));
    @(negedge clk);
    blk_valid  = 1'b0;
    dout_ready = 1'b0;
    checkOutput("busy low after done", 64'(busy), 64'd0);
    checkOutput("done single cycle", 64'(done), 64'd0);
    checkOutput("blk_req idle", 64'(blk_req), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; start = 1'b0; mode = 1'b0; out_len = '0;
    blk_valid = 1'b0; blk_data = '0; dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset dout", dout, 64'd0);
    checkOutput("reset dout_valid", 64'(dout_valid), 64'd0);
    checkOutput("reset blk_req", 64'(blk_req), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;

    //          mode  len pct lat reqs doneCyc fixed
    vecs[0] = '{1'b0,   3, 100, 0, 1,  5, 1'b1};
    vecs[1] = '{1'b1,  20, 100, 0, 2, 23, 1'b0};
    vecs[2] = '{1'b0,   0, 100, 0, 0,  1, 1'b0};
    vecs[3] = '{1'b0,  42,  50, 3, 2,  0, 1'b0};
    vecs[4] = '{1'b0,  21, 100, 0, 1, 23, 1'b0};
    vecs[5] = '{1'b0,  22, 100, 0, 2, 25, 1'b0};
    vecs[6] = '{1'b1,  17,  60, 2, 1,  0, 1'b0};
    vecs[7] = '{1'b1,  35,  70, 4, 3,  0, 1'b0};
    vecs[8] = '{1'b0,   1, 100, 0, 1,  3, 1'b0};
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Reset in the middle of a 10-word squeeze, after five words.
    fillBlocks(1'b0);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; out_len = LEN_W'(10); dout_ready = 1'b1; blk_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    blk_valid = 1'b1; blk_data = blocks[0];
    @(negedge clk);
    blk_valid = 1'b0;
    checkOutput("rst-seq word 0", dout, expWord(0, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst-seq word %0d", k), dout, expWord(k, 1'b0));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid rst dout", dout, 64'd0);
    checkOutput("mid rst dout_valid", 64'(dout_valid), 64'd0);
    checkOutput("mid rst blk_req", 64'(blk_req), 64'd0);
    checkOutput("mid rst busy", 64'(busy), 64'd0);
    checkOutput("mid rst done", 64'(done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("no done after rst", 64'(done), 64'd0);
    end
    dout_ready = 1'b0;
    v = '{1'b0, 2, 100, 0, 1, 4, 1'b0};
    applyStimulus(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
